// File: rtl/alu_cmd_assembler.sv
// Byte-stream command framer for alu32: collects opcode + operand A + operand B
// (little-endian) into one command and hands it off over a valid/ready port.
module alu_cmd_assembler #(
  parameter int unsigned TimeoutCycles_p = 1024,
  parameter int unsigned TimeoutWidth_p  = 16
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        valid_i,
  input  logic [7:0]  data_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [1:0]  opcode_o,
  output logic [31:0] operand_a_o,
  output logic [31:0] operand_b_o,
  input  logic        ready_i,
  output logic        err_o,
  output logic [1:0]  err_cause_o
);

  localparam logic [1:0] StOpcode = 2'd0;
  localparam logic [1:0] StOpA    = 2'd1;
  localparam logic [1:0] StOpB    = 2'd2;
  localparam logic [1:0] StSend   = 2'd3;

  localparam logic [1:0] CauseBadOp   = 2'b01;
  localparam logic [1:0] CauseTimeout = 2'b10;

  localparam bit          TmoEn      = (TimeoutCycles_p != 0);
  localparam int unsigned TmoLastInt = TmoEn ? (TimeoutCycles_p - 1) : 0;
  localparam logic [TimeoutWidth_p-1:0] TmoLast = TimeoutWidth_p'(TmoLastInt);

  logic [1:0]                state_q, state_d;
  logic [1:0]                idx_q, idx_d;
  logic [TimeoutWidth_p-1:0] tmo_q, tmo_d;
  logic [1:0]                opcode_q, opcode_d;
  logic [31:0]               op_a_q, op_a_d;
  logic [31:0]               op_b_q, op_b_d;
  logic                      err_q, err_d;
  logic [1:0]                cause_q, cause_d;

  logic byte_acc;
  logic tmo_hit;
  logic [4:0] byte_lsb;

  assign ready_o     = (state_q != StSend);
  assign valid_o     = (state_q == StSend);
  assign opcode_o    = opcode_q;
  assign operand_a_o = op_a_q;
  assign operand_b_o = op_b_q;
  assign err_o       = err_q;
  assign err_cause_o = cause_q;

  assign byte_acc = valid_i && ready_o;
  assign byte_lsb = {idx_q, 3'b000};
  // An accepted byte in the expiring cycle takes priority over the abort.
  assign tmo_hit  = TmoEn && !byte_acc && (tmo_q == TmoLast);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tmo_d    = '0;
    opcode_d = opcode_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    err_d    = 1'b0;
    cause_d  = cause_q;

    case (state_q)
      StOpcode: begin
        if (byte_acc) begin
          if (data_i[7:2] == 6'd0) begin
            opcode_d = data_i[1:0];
            idx_d    = 2'd0;
            state_d  = StOpA;
          end else begin
            err_d   = 1'b1;
            cause_d = CauseBadOp;
          end
        end
      end

      StOpA, StOpB: begin
        if (byte_acc) begin
          if (state_q == StOpA) begin
            op_a_d[byte_lsb +: 8] = data_i;
          end else begin
            op_b_d[byte_lsb +: 8] = data_i;
          end
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            state_d = (state_q == StOpA) ? StOpB : StSend;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else if (tmo_hit) begin
          // Partial operands are left in place; they are overwritten before use.
          idx_d   = 2'd0;
          state_d = StOpcode;
          err_d   = 1'b1;
          cause_d = CauseTimeout;
        end else if (TmoEn) begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      StSend: begin
        if (ready_i) begin
          state_d = StOpcode;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= StOpcode;
      idx_q    <= 2'd0;
      tmo_q    <= '0;
      opcode_q <= 2'd0;
      op_a_q   <= 32'd0;
      op_b_q   <= 32'd0;
      err_q    <= 1'b0;
      cause_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      opcode_q <= opcode_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      err_q    <= err_d;
      cause_q  <= cause_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_assembler.sv
// Bench for alu_cmd_assembler: directed scenarios on an 8-cycle-timeout instance,
// randomized scoreboard traffic on a timeout-disabled instance sharing the inputs.
module tb_alu_cmd_assembler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [7:0]  data_i = 8'h00;
  logic        ready_i = 1'b0;

  logic        rdy8, vld8, err8;
  logic [1:0]  op8, cause8;
  logic [31:0] a8, b8;
  logic        rdy0, vld0, err0;
  logic [1:0]  op0, cause0;
  logic [31:0] a0, b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_cmd_assembler #(.TimeoutCycles_p(8), .TimeoutWidth_p(16)) dut8 (
    .clk_i(clk), .reset_ni(rst_n), .valid_i(valid_i), .data_i(data_i),
    .ready_o(rdy8), .valid_o(vld8), .opcode_o(op8), .operand_a_o(a8),
    .operand_b_o(b8), .ready_i(ready_i), .err_o(err8), .err_cause_o(cause8)
  );

  alu_cmd_assembler #(.TimeoutCycles_p(0), .TimeoutWidth_p(16)) dut0 (
    .clk_i(clk), .reset_ni(rst_n), .valid_i(valid_i), .data_i(data_i),
    .ready_o(rdy0), .valid_o(vld0), .opcode_o(op0), .operand_a_o(a0),
    .operand_b_o(b0), .ready_i(ready_i), .err_o(err0), .err_cause_o(cause0)
  );

  // Offer one byte; the caller guarantees the block is ready for it.
  task automatic drive_byte(input logic [7:0] b);
    valid_i = 1'b1;
    data_i  = b;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic drive_pkt(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    drive_byte({6'd0, op});
    for (int k = 0; k < 4; k++) drive_byte(a[8*k +: 8]);
    for (int k = 0; k < 4; k++) drive_byte(b[8*k +: 8]);
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({rdy8, vld8, op8, a8, b8, err8, cause8} !== {1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b op=%0d a=%h b=%h err=%b cause=%b, want rdy=1 vld=0 all zero",
               rdy8, vld8, op8, a8, b8, err8, cause8);
    end
    n_checks++;
    if ({rdy0, vld0} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_state_nt: got rdy=%b vld=%b, want rdy=1 vld=0", rdy0, vld0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] pkt [9];
    logic [31:0] ea, eb;
    pkt = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h01, 8'h00, 8'h00, 8'h00};
    ea = {pkt[4], pkt[3], pkt[2], pkt[1]};
    eb = {pkt[8], pkt[7], pkt[6], pkt[5]};
    ready_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      valid_i = 1'b1;
      data_i  = pkt[i];
      n_checks++;
      if (rdy8 !== 1'b1 || vld8 !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_ready byte %0d: got rdy=%b vld=%b, want rdy=1 vld=0", i, rdy8, vld8);
      end
      @(negedge clk);
    end
    valid_i = 1'b0;
    n_checks++;
    if ({vld8, rdy8, op8, a8, b8} !== {1'b1, 1'b0, 2'd1, ea, eb}) begin
      n_fail++;
      $display("FAIL basic_cmd: got vld=%b rdy=%b op=%0d a=%h b=%h, want vld=1 rdy=0 op=1 a=%h b=%h",
               vld8, rdy8, op8, a8, b8, ea, eb);
    end
    @(negedge clk);
    n_checks++;
    if ({vld8, rdy8} !== 2'b01) begin
      n_fail++;
      $display("FAIL basic_after: got vld=%b rdy=%b, want vld=0 rdy=1", vld8, rdy8);
    end
  endtask

  task automatic test_backpressure();
    ready_i = 1'b0;
    drive_pkt(2'd1, 32'h12345678, 32'h00000001);
    valid_i = 1'b1;
    data_i  = 8'h55;
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if ({vld8, rdy8, op8, a8, b8} !== {1'b1, 1'b0, 2'd1, 32'h12345678, 32'h00000001}) begin
        n_fail++;
        $display("FAIL stall_hold cycle %0d: got vld=%b rdy=%b op=%0d a=%h b=%h, want vld=1 rdy=0 op=1 a=12345678 b=00000001",
                 c, vld8, rdy8, op8, a8, b8);
      end
      @(negedge clk);
    end
    ready_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    n_checks++;
    if ({vld8, rdy8, err8} !== 3'b010) begin
      n_fail++;
      $display("FAIL stall_release: got vld=%b rdy=%b err=%b, want vld=0 rdy=1 err=0", vld8, rdy8, err8);
    end
    @(negedge clk);
    n_checks++;
    if ({vld8, err8} !== 2'b00) begin
      n_fail++;
      $display("FAIL stall_byte_consumed: got vld=%b err=%b, want 0 0", vld8, err8);
    end
  endtask

  task automatic test_bad_opcode();
    ready_i = 1'b1;
    drive_byte(8'h83);
    n_checks++;
    if ({err8, cause8, rdy8} !== {1'b1, 2'b01, 1'b1}) begin
      n_fail++;
      $display("FAIL badop_err: got err=%b cause=%b rdy=%b, want err=1 cause=01 rdy=1", err8, cause8, rdy8);
    end
    drive_byte(8'h02);
    n_checks++;
    if (err8 !== 1'b0) begin
      n_fail++;
      $display("FAIL badop_pulse_width: got err=%b, want 0", err8);
    end
    for (int k = 0; k < 4; k++) drive_byte(8'hFF);
    drive_byte(8'h02);
    for (int k = 0; k < 3; k++) drive_byte(8'h00);
    n_checks++;
    if ({vld8, op8, a8, b8, cause8} !== {1'b1, 2'd2, 32'hFFFFFFFF, 32'h00000002, 2'b01}) begin
      n_fail++;
      $display("FAIL badop_cmd: got vld=%b op=%0d a=%h b=%h cause=%b, want vld=1 op=2 a=ffffffff b=00000002 cause=01",
               vld8, op8, a8, b8, cause8);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    ready_i = 1'b1;
    drive_byte(8'h01);
    drive_byte(8'hAA);
    drive_byte(8'hBB);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      n_checks++;
      if (err8 !== 1'b0) begin
        n_fail++;
        $display("FAIL tmo_early idle %0d: got err=%b, want 0", i, err8);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({err8, cause8, rdy8, vld8} !== {1'b1, 2'b10, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL tmo_fire: got err=%b cause=%b rdy=%b vld=%b, want err=1 cause=10 rdy=1 vld=0",
               err8, cause8, rdy8, vld8);
    end
    drive_pkt(2'd3, 32'hCAFEF00D, 32'h00000007);
    n_checks++;
    if ({vld8, op8, a8, b8} !== {1'b1, 2'd3, 32'hCAFEF00D, 32'h00000007}) begin
      n_fail++;
      $display("FAIL tmo_div_cmd: got vld=%b op=%0d a=%h b=%h, want vld=1 op=3 a=cafef00d b=00000007",
               vld8, op8, a8, b8);
    end
    @(negedge clk);
    drive_byte(8'h01);
    drive_byte(8'h11);
    drive_byte(8'h22);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      n_checks++;
      if (err8 !== 1'b0) begin
        n_fail++;
        $display("FAIL tmo_seven idle %0d: got err=%b, want 0", i, err8);
      end
    end
    drive_byte(8'h33);
    drive_byte(8'h44);
    for (int k = 0; k < 4; k++) drive_byte(8'h55 + 8'h11 * k[7:0]);
    n_checks++;
    if ({vld8, op8, a8, b8, err8, cause8} !== {1'b1, 2'd1, 32'h44332211, 32'h88776655, 1'b0, 2'b10}) begin
      n_fail++;
      $display("FAIL tmo_seven_cmd: got vld=%b op=%0d a=%h b=%h err=%b cause=%b, want vld=1 op=1 a=44332211 b=88776655 err=0 cause=10",
               vld8, op8, a8, b8, err8, cause8);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    ready_i = 1'b1;
    drive_byte(8'h01);
    drive_byte(8'h11);
    drive_byte(8'h22);
    drive_byte(8'h33);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rdy8, vld8, op8, a8, b8, err8, cause8, vld0} !== {1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL areset_midpkt: got rdy=%b vld=%b op=%0d a=%h b=%h err=%b cause=%b, want rdy=1 vld=0 all zero",
               rdy8, vld8, op8, a8, b8, err8, cause8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ready_i = 1'b0;
    drive_pkt(2'd2, 32'h0BADBEEF, 32'h00010002);
    n_checks++;
    if (vld8 !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_presend: got vld=%b, want 1", vld8);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({vld8, rdy8, op8, a8, b8, vld0} !== {1'b0, 1'b1, 2'd0, 32'd0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL areset_send: got vld=%b rdy=%b op=%0d a=%h b=%h, want vld=0 rdy=1 zeros", vld8, rdy8, op8, a8, b8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ready_i = 1'b1;
    drive_pkt(2'd0, 32'h89ABCDEF, 32'h76543210);
    n_checks++;
    if ({vld8, op8, a8, b8} !== {1'b1, 2'd0, 32'h89ABCDEF, 32'h76543210}) begin
      n_fail++;
      $display("FAIL areset_next_cmd: got vld=%b op=%0d a=%h b=%h, want vld=1 op=0 a=89abcdef b=76543210",
               vld8, op8, a8, b8);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [65:0] exp_q [$];
    logic [65:0] e;
    int got = 0;
    int cyc = 0;
    int errs = 0;
    fork
      begin
        for (int p = 0; p < 200; p++) begin
          logic [1:0]  op;
          logic [31:0] a, b;
          logic [7:0]  bytes [9];
          bit acc;
          int gap;
          op = 2'($urandom_range(0, 3));
          a  = $urandom;
          b  = $urandom;
          exp_q.push_back({op, a, b});
          bytes[0] = {6'd0, op};
          for (int k = 0; k < 4; k++) begin
            bytes[1+k] = a[8*k +: 8];
            bytes[5+k] = b[8*k +: 8];
          end
          for (int k = 0; k < 9; k++) begin
            gap = ($urandom_range(0, 15) == 0) ? $urandom_range(9, 20) : $urandom_range(0, 2);
            valid_i = 1'b0;
            repeat (gap) @(negedge clk);
            valid_i = 1'b1;
            data_i  = bytes[k];
            do begin
              acc = rdy0;
              @(negedge clk);
            end while (!acc);
          end
          valid_i = 1'b0;
        end
      end
      begin
        while (got < 200 && cyc < 40000) begin
          @(negedge clk);
          cyc++;
          ready_i = 1'($urandom_range(0, 1));
          if (err0) errs++;
          if (vld0 && ready_i) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL rand_extra: got op=%0d a=%h b=%h, want no command", op0, a0, b0);
            end else begin
              e = exp_q.pop_front();
              if ({op0, a0, b0} !== e) begin
                n_fail++;
                $display("FAIL rand_cmd %0d: got op=%0d a=%h b=%h, want op=%0d a=%h b=%h",
                         got, op0, a0, b0, e[65:64], e[63:32], e[31:0]);
              end
            end
            got++;
          end
        end
      end
    join
    n_checks++;
    if (got != 200 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_count: got %0d delivered with %0d pending, want 200 delivered 0 pending", got, exp_q.size());
    end
    ready_i = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (vld0 !== 1'b0 || errs != 0) begin
      n_fail++;
      $display("FAIL rand_tail: got vld=%b errs=%0d, want vld=0 errs=0", vld0, errs);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bad_opcode();
    test_timeout();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
